// File: rtl/ubx_stream_parser.sv
`default_nettype none
// ============================================================================
//  Module      : ubx_stream_parser
//  Description : UBX frame parser for the GNSS UART RX byte stream: sync hunt,
//                header decode, payload streaming, Fletcher-8 check, counters.
//                Optional inter-byte timeout enabled by macro UBX_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ubx_stream_parser #(
    parameter int MAX_PYL_LEN    = 512,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             i_uart_clk,
    input  logic             i_uart_rst,
    input  logic [7:0]       i_data_tdata,
    input  logic             i_data_tvalid,
    output logic [7:0]       o_class,
    output logic [7:0]       o_id,
    output logic [15:0]      o_length,
    output logic             o_hdr_tvalid,
    output logic [7:0]       o_pyl_tdata,
    output logic             o_pyl_tvalid,
    output logic             o_pyl_tlast,
    output logic             o_pkt_done,
    output logic             o_pkt_error,
    output logic             o_len_error,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    typedef enum logic [3:0] {
        S_SYNC1   = 4'd0,
        S_SYNC2   = 4'd1,
        S_CLASS   = 4'd2,
        S_ID      = 4'd3,
        S_LEN_L   = 4'd4,
        S_LEN_H   = 4'd5,
        S_PAYLOAD = 4'd6,
        S_CK_A    = 4'd7,
        S_CK_B    = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    localparam logic [7:0]       c_SYNC_1  = 8'hB5;
    localparam logic [7:0]       c_SYNC_2  = 8'h62;
    localparam logic [15:0]      c_MAX_LEN = 16'(MAX_PYL_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state_q,    w_state_d;
    logic [7:0]       r_ck_a_q,     w_ck_a_d;
    logic [7:0]       r_ck_b_q,     w_ck_b_d;
    logic [7:0]       r_rx_a_q,     w_rx_a_d;
    logic             r_mismatch_q, w_mismatch_d;
    logic [7:0]       r_cls_tmp_q,  w_cls_tmp_d;
    logic [7:0]       r_id_tmp_q,   w_id_tmp_d;
    logic [7:0]       r_len_lo_q,   w_len_lo_d;
    logic [15:0]      r_pcnt_q,     w_pcnt_d;
    logic [7:0]       r_class_q,    w_class_d;
    logic [7:0]       r_id_q,       w_id_d;
    logic [15:0]      r_length_q,   w_length_d;
    logic             r_hdr_q,      w_hdr_d;
    logic [7:0]       r_pyl_data_q, w_pyl_data_d;
    logic             r_pyl_vld_q,  w_pyl_vld_d;
    logic             r_pyl_last_q, w_pyl_last_d;
    logic             r_done_q,     w_done_d;
    logic             r_pkt_err_q,  w_pkt_err_d;
    logic             r_len_err_q,  w_len_err_d;
    logic [CNT_W-1:0] r_pkt_cnt_q,  w_pkt_cnt_d;
    logic [CNT_W-1:0] r_err_cnt_q,  w_err_cnt_d;
    logic             w_tmo_d;

    logic [15:0] w_len;
    logic [7:0]  w_ck_a_upd;
    logic [7:0]  w_ck_b_upd;

    assign w_len      = {i_data_tdata, r_len_lo_q};
    assign w_ck_a_upd = r_ck_a_q + i_data_tdata;
    assign w_ck_b_upd = r_ck_b_q + w_ck_a_upd;

`ifdef UBX_TIMEOUT_EN
    localparam int             c_IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [c_IDLE_W-1:0] r_idle_q, w_idle_d;
    logic                r_tmo_q;

    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) begin
            r_idle_q <= '0;
            r_tmo_q  <= 1'b0;
        end else begin
            r_idle_q <= w_idle_d;
            r_tmo_q  <= w_tmo_d;
        end
    end

    assign o_timeout = r_tmo_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_ck_a_d     = r_ck_a_q;
        w_ck_b_d     = r_ck_b_q;
        w_rx_a_d     = r_rx_a_q;
        w_mismatch_d = r_mismatch_q;
        w_cls_tmp_d  = r_cls_tmp_q;
        w_id_tmp_d   = r_id_tmp_q;
        w_len_lo_d   = r_len_lo_q;
        w_pcnt_d     = r_pcnt_q;
        w_class_d    = r_class_q;
        w_id_d       = r_id_q;
        w_length_d   = r_length_q;
        w_pyl_data_d = r_pyl_data_q;
        w_hdr_d      = 1'b0;
        w_pyl_vld_d  = 1'b0;
        w_pyl_last_d = 1'b0;
        w_done_d     = 1'b0;
        w_pkt_err_d  = 1'b0;
        w_len_err_d  = 1'b0;
        w_tmo_d      = 1'b0;
        w_pkt_cnt_d  = r_pkt_cnt_q;
        w_err_cnt_d  = r_err_cnt_q;

        // DONE is not gated by tvalid; its byte is treated as SYNC1 input
        case (r_state_q)
            S_SYNC1: if (i_data_tvalid && i_data_tdata == c_SYNC_1) w_state_d = S_SYNC2;
            S_SYNC2: if (i_data_tvalid) begin
                if (i_data_tdata == c_SYNC_2) begin
                    w_state_d = S_CLASS;
                    w_ck_a_d  = 8'h00;
                    w_ck_b_d  = 8'h00;
                end else if (i_data_tdata != c_SYNC_1) begin
                    w_state_d = S_SYNC1;
                end
            end
            S_CLASS, S_ID, S_LEN_L, S_LEN_H, S_PAYLOAD: if (i_data_tvalid) begin
                w_ck_a_d = w_ck_a_upd;
                w_ck_b_d = w_ck_b_upd;
                case (r_state_q)
                    S_CLASS: begin w_cls_tmp_d = i_data_tdata; w_state_d = S_ID;    end
                    S_ID:    begin w_id_tmp_d  = i_data_tdata; w_state_d = S_LEN_L; end
                    S_LEN_L: begin w_len_lo_d  = i_data_tdata; w_state_d = S_LEN_H; end
                    S_LEN_H: begin
                        if (w_len > c_MAX_LEN) begin
                            w_len_err_d = 1'b1;
                            w_state_d   = S_SYNC1;
                        end else begin
                            w_hdr_d    = 1'b1;
                            w_class_d  = r_cls_tmp_q;
                            w_id_d     = r_id_tmp_q;
                            w_length_d = w_len;
                            w_pcnt_d   = 16'd0;
                            w_state_d  = (w_len == 16'd0) ? S_CK_A : S_PAYLOAD;
                        end
                    end
                    default: begin
                        w_pyl_vld_d  = 1'b1;
                        w_pyl_data_d = i_data_tdata;
                        w_pcnt_d     = r_pcnt_q + 16'd1;
                        if (r_pcnt_q == r_length_q - 16'd1) begin
                            w_pyl_last_d = 1'b1;
                            w_state_d    = S_CK_A;
                        end
                    end
                endcase
            end
            S_CK_A: if (i_data_tvalid) begin
                w_rx_a_d  = i_data_tdata;
                w_state_d = S_CK_B;
            end
            S_CK_B: if (i_data_tvalid) begin
                w_mismatch_d = ({r_rx_a_q, i_data_tdata} != {r_ck_a_q, r_ck_b_q});
                w_state_d    = S_DONE;
            end
            S_DONE: begin
                w_done_d    = 1'b1;
                w_pkt_err_d = r_mismatch_q;
                w_state_d   = (i_data_tvalid && i_data_tdata == c_SYNC_1) ? S_SYNC2 : S_SYNC1;
            end
            default: w_state_d = S_SYNC1;
        endcase

`ifdef UBX_TIMEOUT_EN
        w_idle_d = i_data_tvalid ? '0 : ((r_idle_q == c_IDLE_MAX) ? r_idle_q : r_idle_q + 1'b1);
        // Fires on the TIMEOUT_CYCLES-th consecutive idle clock inside a frame
        if (!i_data_tvalid && r_idle_q == c_IDLE_LAST &&
            r_state_q != S_SYNC1 && r_state_q != S_SYNC2 && r_state_q != S_DONE) begin
            w_tmo_d   = 1'b1;
            w_state_d = S_SYNC1;
            w_ck_a_d  = 8'h00;
            w_ck_b_d  = 8'h00;
        end
`endif

        if (w_done_d && !r_mismatch_q && r_pkt_cnt_q != c_CNT_MAX)
            w_pkt_cnt_d = r_pkt_cnt_q + 1'b1;
        if (((w_done_d && r_mismatch_q) || w_len_err_d || w_tmo_d) && r_err_cnt_q != c_CNT_MAX)
            w_err_cnt_d = r_err_cnt_q + 1'b1;
    end

    always_ff @(posedge i_uart_clk) begin
        if (i_uart_rst) begin
            r_state_q    <= S_SYNC1;
            r_ck_a_q     <= 8'h00;
            r_ck_b_q     <= 8'h00;
            r_rx_a_q     <= 8'h00;
            r_mismatch_q <= 1'b0;
            r_cls_tmp_q  <= 8'h00;
            r_id_tmp_q   <= 8'h00;
            r_len_lo_q   <= 8'h00;
            r_pcnt_q     <= 16'd0;
            r_class_q    <= 8'h00;
            r_id_q       <= 8'h00;
            r_length_q   <= 16'd0;
            r_hdr_q      <= 1'b0;
            r_pyl_data_q <= 8'h00;
            r_pyl_vld_q  <= 1'b0;
            r_pyl_last_q <= 1'b0;
            r_done_q     <= 1'b0;
            r_pkt_err_q  <= 1'b0;
            r_len_err_q  <= 1'b0;
            r_pkt_cnt_q  <= '0;
            r_err_cnt_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_ck_a_q     <= w_ck_a_d;
            r_ck_b_q     <= w_ck_b_d;
            r_rx_a_q     <= w_rx_a_d;
            r_mismatch_q <= w_mismatch_d;
            r_cls_tmp_q  <= w_cls_tmp_d;
            r_id_tmp_q   <= w_id_tmp_d;
            r_len_lo_q   <= w_len_lo_d;
            r_pcnt_q     <= w_pcnt_d;
            r_class_q    <= w_class_d;
            r_id_q       <= w_id_d;
            r_length_q   <= w_length_d;
            r_hdr_q      <= w_hdr_d;
            r_pyl_data_q <= w_pyl_data_d;
            r_pyl_vld_q  <= w_pyl_vld_d;
            r_pyl_last_q <= w_pyl_last_d;
            r_done_q     <= w_done_d;
            r_pkt_err_q  <= w_pkt_err_d;
            r_len_err_q  <= w_len_err_d;
            r_pkt_cnt_q  <= w_pkt_cnt_d;
            r_err_cnt_q  <= w_err_cnt_d;
        end
    end

    assign o_class      = r_class_q;
    assign o_id         = r_id_q;
    assign o_length     = r_length_q;
    assign o_hdr_tvalid = r_hdr_q;
    assign o_pyl_tdata  = r_pyl_data_q;
    assign o_pyl_tvalid = r_pyl_vld_q;
    assign o_pyl_tlast  = r_pyl_last_q;
    assign o_pkt_done   = r_done_q;
    assign o_pkt_error  = r_pkt_err_q;
    assign o_len_error  = r_len_err_q;
    assign o_pkt_cnt    = r_pkt_cnt_q;
    assign o_err_cnt    = r_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ubx_stream_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ubx_stream_parser
//  Description : Scoreboard bench for ubx_stream_parser with random UBX traffic
//                (timeout scenarios only when UBX_TIMEOUT_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ubx_stream_parser;

    localparam int MAX_PYL_LEN    = 40;
    localparam int CNT_W          = 3;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int CNT_MAX        = (1 << CNT_W) - 1;

    localparam int K_HDR = 1, K_PYL = 2, K_DONE = 3, K_LEN = 4, K_TMO = 5;

    typedef struct {
        int          kind;
        logic [7:0]  cls;
        logic [7:0]  id;
        logic [15:0] len;
        logic [7:0]  data;
        logic        flag;
        int          pc;
        int          ec;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       tdata = 8'h00;
    logic             tvalid = 1'b0;
    logic [7:0]       o_class, o_id, o_pyl_tdata;
    logic [15:0]      o_length;
    logic             o_hdr_tvalid, o_pyl_tvalid, o_pyl_tlast, o_pkt_done;
    logic             o_pkt_error, o_len_error, o_timeout;
    logic [CNT_W-1:0] o_pkt_cnt, o_err_cnt;

    ubx_stream_parser #(
        .MAX_PYL_LEN(MAX_PYL_LEN), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_uart_clk(clk), .i_uart_rst(rst),
        .i_data_tdata(tdata), .i_data_tvalid(tvalid),
        .o_class(o_class), .o_id(o_id), .o_length(o_length), .o_hdr_tvalid(o_hdr_tvalid),
        .o_pyl_tdata(o_pyl_tdata), .o_pyl_tvalid(o_pyl_tvalid), .o_pyl_tlast(o_pyl_tlast),
        .o_pkt_done(o_pkt_done), .o_pkt_error(o_pkt_error), .o_len_error(o_len_error),
        .o_timeout(o_timeout), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  exp_q[$];
    int   m_pc = 0, m_ec = 0;
    logic [7:0]  cur_cls = 8'h00, cur_id = 8'h00;
    logic [15:0] cur_len = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: expected-event producers -------------
    function automatic int sat_inc(input int v);
        return (v == CNT_MAX) ? v : v + 1;
    endfunction

    task automatic exp_push(input int kind, input logic [7:0] data, input logic flag);
        ev_t e;
        e.kind = kind; e.cls = cur_cls; e.id = cur_id; e.len = cur_len;
        e.data = data; e.flag = flag; e.pc = m_pc; e.ec = m_ec;
        exp_q.push_back(e);
    endtask

    task automatic exp_hdr(input logic [7:0] c, input logic [7:0] i, input logic [15:0] l);
        cur_cls = c; cur_id = i; cur_len = l;
        exp_push(K_HDR, 8'h00, 1'b0);
    endtask

    task automatic exp_done(input logic err);
        if (err) m_ec = sat_inc(m_ec); else m_pc = sat_inc(m_pc);
        exp_push(K_DONE, 8'h00, err);
    endtask

    task automatic exp_err(input int kind);
        m_ec = sat_inc(m_ec);
        exp_push(kind, 8'h00, 1'b0);
    endtask

    // ---------------- stimulus ----------------------------------------------
    task automatic send_byte(input logic [7:0] b);
        tdata = b; tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tdata = 8'($urandom);
    endtask

    task automatic send_bytes(input logic [7:0] bq[$], input int max_gap);
        foreach (bq[k]) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            send_byte(bq[k]);
        end
    endtask

    // Builds a frame from its fields, queues expected events, then sends it.
    task automatic frame(input logic [7:0] c, input logic [7:0] i, input logic [15:0] l,
                         input logic [7:0] pyl[$], input logic [7:0] ck_flip);
        logic [7:0] bq[$];
        logic [7:0] body[$];
        int a = 0, b = 0;
        body = {c, i, l[7:0], l[15:8]};
        bq   = {8'hB5, 8'h62};
        if (int'(l) > MAX_PYL_LEN) begin
            exp_err(K_LEN);
            bq = {bq, body};
        end else begin
            body = {body, pyl};
            foreach (body[k]) begin
                a = (a + body[k]) % 256;
                b = (b + a) % 256;
            end
            exp_hdr(c, i, l);
            foreach (pyl[k]) exp_push(K_PYL, pyl[k], (k == pyl.size() - 1));
            exp_done(ck_flip != 8'h00);
            bq = {bq, body, 8'(a), 8'(b) ^ ck_flip};
        end
        send_bytes(bq, 3);
    endtask

    task automatic garbage();
        logic [7:0] g[$];
        logic [7:0] x;
        repeat ($urandom_range(0, 3)) begin
            do x = 8'($urandom); while (x == 8'hB5);
            g.push_back(x);
        end
        if ($urandom_range(0, 3) == 0) begin
            do x = 8'($urandom); while (x == 8'hB5 || x == 8'h62);
            g = {g, 8'hB5, x};
        end
        if ($urandom_range(0, 3) == 0) g.push_back(8'hB5);
        send_bytes(g, 2);
    endtask

    task automatic rand_frame();
        logic [7:0]  pyl[$];
        logic [15:0] l;
        logic [7:0]  flip = 8'h00;
        int          sel = $urandom_range(0, 9);
        case (sel)
            0:       l = 16'd0;
            1:       l = 16'(MAX_PYL_LEN);
            2:       l = 16'(MAX_PYL_LEN + 1);
            3:       l = 16'($urandom_range(MAX_PYL_LEN + 2, 65535));
            default: l = 16'($urandom_range(1, 12));
        endcase
        if (sel == 4 || sel == 5) flip = 8'($urandom_range(1, 255));
        if (int'(l) <= MAX_PYL_LEN)
            for (int k = 0; k < int'(l); k++)
                pyl.push_back(($urandom_range(0, 3) == 0) ? 8'hB5 : 8'($urandom));
        garbage();
        frame(8'($urandom), 8'($urandom), l, pyl, flip);
    endtask

    // ---------------- monitor / scoreboard ----------------------------------
    ev_t mon_e;
    bit  mon_ok;

    task automatic pop_expect(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(kind), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            ok = (e.kind == kind);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_hdr_tvalid) begin
                pop_expect(K_HDR, mon_e, mon_ok);
                if (mon_ok) begin
                    check("hdr_class", 32'(o_class), 32'(mon_e.cls));
                    check("hdr_id", 32'(o_id), 32'(mon_e.id));
                    check("hdr_length", 32'(o_length), 32'(mon_e.len));
                end
            end
            if (o_pyl_tvalid) begin
                pop_expect(K_PYL, mon_e, mon_ok);
                if (mon_ok) begin
                    check("pyl_data", 32'(o_pyl_tdata), 32'(mon_e.data));
                    check("pyl_last", 32'(o_pyl_tlast), 32'(mon_e.flag));
                    check("pyl_hold_class", 32'(o_class), 32'(mon_e.cls));
                end
            end
            if (o_pkt_done) begin
                pop_expect(K_DONE, mon_e, mon_ok);
                if (mon_ok) begin
                    check("pkt_error", 32'(o_pkt_error), 32'(mon_e.flag));
                    check("done_pkt_cnt", 32'(o_pkt_cnt), 32'(mon_e.pc));
                    check("done_err_cnt", 32'(o_err_cnt), 32'(mon_e.ec));
                    check("done_hold_len", 32'(o_length), 32'(mon_e.len));
                end
            end
            if (o_len_error) begin
                pop_expect(K_LEN, mon_e, mon_ok);
                if (mon_ok) begin
                    check("lenerr_err_cnt", 32'(o_err_cnt), 32'(mon_e.ec));
                    check("lenerr_pkt_cnt", 32'(o_pkt_cnt), 32'(mon_e.pc));
                end
            end
            if (o_timeout) begin
                pop_expect(K_TMO, mon_e, mon_ok);
                if (mon_ok) begin
                    check("tmo_err_cnt", 32'(o_err_cnt), 32'(mon_e.ec));
                    check("tmo_no_tlast", 32'(o_pyl_tlast), 32'd0);
                end
            end
        end
    end

    // ---------------- main sequence -----------------------------------------
    initial begin
        logic [7:0] bq[$];
        logic [7:0] pyl[$];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_class", 32'(o_class), 32'd0);
        check("rst_id", 32'(o_id), 32'd0);
        check("rst_length", 32'(o_length), 32'd0);
        check("rst_hdr", 32'(o_hdr_tvalid), 32'd0);
        check("rst_pyl", 32'({o_pyl_tdata, o_pyl_tvalid, o_pyl_tlast}), 32'd0);
        check("rst_done", 32'({o_pkt_done, o_pkt_error}), 32'd0);
        check("rst_errs", 32'({o_len_error, o_timeout}), 32'd0);
        check("rst_cnts", 32'({o_pkt_cnt, o_err_cnt}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ACK-ACK literal frame
        exp_hdr(8'h05, 8'h01, 16'd2);
        exp_push(K_PYL, 8'h06, 1'b0);
        exp_push(K_PYL, 8'h01, 1'b1);
        exp_done(1'b0);
        bq = {8'hB5, 8'h62, 8'h05, 8'h01, 8'h02, 8'h00, 8'h06, 8'h01, 8'h0F, 8'h38};
        send_bytes(bq, 2);
        // same frame, bad CK_B
        exp_hdr(8'h05, 8'h01, 16'd2);
        exp_push(K_PYL, 8'h06, 1'b0);
        exp_push(K_PYL, 8'h01, 1'b1);
        exp_done(1'b1);
        bq[9] = 8'h39;
        send_bytes(bq, 2);
        // zero-length poll
        exp_hdr(8'h06, 8'h01, 16'd0);
        exp_done(1'b0);
        bq = {8'hB5, 8'h62, 8'h06, 8'h01, 8'h00, 8'h00, 8'h07, 8'h1B};
        send_bytes(bq, 2);
        // garbage + B5 B5 62 resync
        exp_hdr(8'h05, 8'h01, 16'd2);
        exp_push(K_PYL, 8'h06, 1'b0);
        exp_push(K_PYL, 8'h01, 1'b1);
        exp_done(1'b0);
        bq = {8'h00, 8'hB5, 8'hB5, 8'h62, 8'h05, 8'h01, 8'h02, 8'h00, 8'h06, 8'h01, 8'h0F, 8'h38};
        send_bytes(bq, 2);
        // oversize header then a valid frame
        pyl = {8'hB5, 8'h62};
        frame(8'h05, 8'h01, 16'h0201, pyl, 8'h00);
        frame(8'h0A, 8'h04, 16'd2, pyl, 8'h00);
        repeat (4) @(posedge clk);
        #1;

        // reset mid-frame: no done, counters cleared
        exp_hdr(8'h01, 8'h02, 16'd5);
        exp_push(K_PYL, 8'hAA, 1'b0);
        exp_push(K_PYL, 8'hBB, 1'b0);
        bq = {8'hB5, 8'h62, 8'h01, 8'h02, 8'h05, 8'h00, 8'hAA, 8'hBB};
        send_bytes(bq, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_pc = 0; m_ec = 0; cur_cls = 8'h00; cur_id = 8'h00; cur_len = 16'd0;
        check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
        check("midrst_cnts", 32'({o_pkt_cnt, o_err_cnt}), 32'd0);
        check("midrst_length", 32'(o_length), 32'd0);

`ifdef UBX_TIMEOUT_EN
        // stall after one payload byte, then after the class byte
        exp_hdr(8'h07, 8'h08, 16'd5);
        exp_push(K_PYL, 8'h11, 1'b0);
        exp_err(K_TMO);
        bq = {8'hB5, 8'h62, 8'h07, 8'h08, 8'h05, 8'h00, 8'h11};
        send_bytes(bq, 2);
        repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
        #1;
        exp_err(K_TMO);
        bq = {8'hB5, 8'h62, 8'h07};
        send_bytes(bq, 2);
        repeat (TIMEOUT_CYCLES + 10) @(posedge clk);
        #1;
`endif

        for (int n = 0; n < 60; n++) rand_frame();

        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_pkt_cnt", 32'(o_pkt_cnt), 32'(m_pc));
        check("final_err_cnt", 32'(o_err_cnt), 32'(m_ec));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
